// File: rtl/gf2mz_add.sv
// Coefficient-wise GF(2^M) polynomial add: streams se[k] and s[k] out of two RAMs
// and writes se[k]^s[k] back one cycle later. Optional zero flag: GF2MZ_ADD_ZERO_CHECK_EN.
module gf2mz_add #(
  parameter int M  = 67,
  parameter int N  = 47,
  parameter int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          start,
  output logic          done,
  output logic          busy,
  output logic [AW-1:0] a_addr,
  output logic          a_en,
  input  logic [M-1:0]  a_dout,
  output logic [AW-1:0] b_addr,
  output logic          b_en,
  input  logic [M-1:0]  b_dout,
  output logic [AW-1:0] w_addr,
  output logic          w_en,
  output logic [M-1:0]  w_din
`ifdef GF2MZ_ADD_ZERO_CHECK_EN
  ,
  output logic          zero
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    DONE
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(N - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          w_en_q, w_en_d;
  logic [AW-1:0] w_addr_q, w_addr_d;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        // Counter parks at 0 once the last index is issued, so it never wraps past N-1.
        if (cnt_q == LAST) begin
          state_d = FLUSH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rd_en    = (state_q == RUN);
    rd_addr  = rd_en ? cnt_q : '0;
    w_en_d   = rd_en;
    w_addr_d = rd_addr;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      w_en_q   <= 1'b0;
      w_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      w_en_q   <= w_en_d;
      w_addr_q <= w_addr_d;
    end
  end

  assign a_en   = rd_en;
  assign b_en   = rd_en;
  assign a_addr = rd_addr;
  assign b_addr = rd_addr;
  assign w_en   = w_en_q;
  assign w_addr = w_addr_q;
  // RAM data is valid exactly in the cycle after the read, which is the write cycle.
  assign w_din  = w_en_q ? (a_dout ^ b_dout) : '0;
  assign done   = (state_q == DONE);
  assign busy   = (state_q == RUN) || (state_q == FLUSH);

`ifdef GF2MZ_ADD_ZERO_CHECK_EN
  logic zero_q, zero_d;

  always_comb begin
    zero_d = zero_q;
    if ((state_q == IDLE) && start) begin
      zero_d = 1'b1;
    end else if (w_en_q && (w_din != '0)) begin
      zero_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      zero_q <= 1'b1;
    end else begin
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`endif

endmodule

// File: doc/gf2mz_add.md
GF2MZ_ADD -- requirements
Module: gf2mz_add

Interface
REQ-001 SHALL have parameter M, default 67, meaning coefficient width (GF(2^M) element bits).
REQ-002 SHALL have parameter N, default 47, meaning number of polynomial coefficients.
REQ-003 SHALL have parameter AW, default clog2(N), meaning coefficient address width.
REQ-004 SHALL have port clk  input  1  the single clock; all state is updated on the rising edge.
REQ-005 SHALL have port rst_b  input  1  reset, asynchronous and active-low.
REQ-006 SHALL have port start  input  1  single-cycle request to compute s = se + s.
REQ-007 SHALL have port done  output  1  single-cycle completion pulse.
REQ-008 SHALL have port busy  output  1  high from the accepted start until done.
REQ-009 SHALL have port a_addr  output  AW  read address into the se coefficient RAM.
REQ-010 SHALL have port a_en  output  1  read enable for the se RAM.
REQ-011 SHALL have port a_dout  input  M  se coefficient, valid one cycle after a_en.
REQ-012 SHALL have port b_addr  output  AW  read address into the s RAM.
REQ-013 SHALL have port b_en  output  1  read enable for the s RAM.
REQ-014 SHALL have port b_dout  input  M  s coefficient, valid one cycle after b_en.
REQ-015 SHALL have port w_addr  output  AW  result write address.
REQ-016 SHALL have port w_en  output  1  result write strobe.
REQ-017 SHALL have port w_din  output  M  result coefficient a_dout XOR b_dout.
REQ-018 SHALL have port zero  output  1  result-is-zero flag; present only with GF2MZ_ADD_ZERO_CHECK_EN defined.

Function
REQ-019 SHALL implement FSM states IDLE, RUN, FLUSH and DONE.
REQ-020 SHALL move IDLE->RUN on the edge where start=1 and the state is IDLE.
REQ-021 SHALL ignore start in any state other than IDLE, with no restart and no queueing.
REQ-022 SHALL, in RUN, drive a_en=b_en=1 with a_addr=b_addr=k, where k=0..N-1 and k increments each cycle.
REQ-023 SHALL move RUN->FLUSH in the cycle after issuing k=N-1, with read enables low in FLUSH.
REQ-024 SHALL drive, one cycle after each read issue k, w_en=1, w_addr=k and w_din=a_dout^b_dout.
REQ-025 SHALL move FLUSH->DONE after the write of k=N-1, and DONE->IDLE unconditionally after one cycle.
REQ-026 SHALL assert done for exactly the single DONE cycle, N+2 cycles after the start edge.
REQ-027 SHALL hold busy=1 in RUN and FLUSH and busy=0 in IDLE and DONE.
REQ-028 SHALL hold read and write addresses at 0 when not enabled, with no address exceeding N-1.
REQ-029 SHALL size the address counter to AW bits and stop it at N-1 without wrapping.
REQ-030 SHALL be correct when the write target is the s RAM (in-place), since each write address trails its read by one cycle.
REQ-031 SHALL accept a start pulse in the cycle directly after DONE and begin a new run.

Reset
REQ-032 SHALL, on rst_b=0 (asynchronous), force state IDLE, counter 0, and done, busy, a_en, b_en and w_en to 0.
REQ-033 SHALL force all address and data outputs to 0 on reset, and zero to 1 when compiled in.
REQ-034 SHALL, on reset mid-run, abandon the run with no further writes and no done pulse.

Configuration
REQ-035 SHALL, with GF2MZ_ADD_ZERO_CHECK_EN defined, set zero=1 at RUN entry and clear it on any write with w_din!=0, so that zero is valid when done=1 and holds until the next start.
REQ-036 SHALL, with GF2MZ_ADD_ZERO_CHECK_EN undefined, omit the zero port and its logic entirely, with all other behaviour unchanged.

Verification
REQ-037 Bench SHALL cover: N=47, se[k]=k+1, s[k]=0 -> 47 writes with w_din[k]=k+1, done exactly 49 cycles after start.
REQ-038 Bench SHALL cover: se[k]=s[k]=0x5A5A for all k -> every w_din=0, zero=1 at done (macro on).
REQ-039 Bench SHALL cover: se identical to s except s[46]^=1 -> only w_din[46]=1, zero=0 at done.
REQ-040 Bench SHALL cover: start re-pulsed at cycles 5 and 20 of a run -> ignored, single done, 47 writes.
REQ-041 Bench SHALL cover: rst_b low at cycle 10 of a run -> outputs zero immediately, no done; a fresh start then completes normally.
REQ-042 Bench SHALL cover: start in the cycle after done, in-place into the s RAM -> second run correct, s[k] equal to original s[k]^2·se[k]... i.e. s restored after two runs.
